mu_sequencer: RTL
=================

Name: mu_sequencer

Overview:
Sequences the multi-cycle multiply unit (MU) in the EX stage. When the EX controller classifies an R-type instruction as an M-extension multiply, this block latches the operands and pulses a start to the MU. It stalls the pipeline until mul_done, then presents a one-cycle writeback result. It also handles pipeline flushes and detects a hung MU with a timeout counter.

Parameters:
XLEN, 32, operand/result width
TIMEOUT, 64, max cycles spent in WAIT before abort; must be >= 2
CNT_W, $clog2(TIMEOUT)+1, timeout counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  EX stage holds a valid instruction this cycle
is_mul  input  1  EX result select = MU (ifuresctl==1)
mulctl_in  input  2  MU op from EX controller: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu
rs1_data  input  XLEN  operand A
rs2_data  input  XLEN  operand B
rd_in  input  5  destination register
flush  input  1  kill the in-flight EX instruction
mul_done  input  1  MU result valid (level, sampled only in WAIT)
mul_result  input  XLEN  MU result
mul_start  output  1  one-cycle start pulse to MU
mul_abort  output  1  one-cycle abort pulse to MU
mul_op  output  2  registered op to MU
mul_a  output  XLEN  registered operand A
mul_b  output  XLEN  registered operand B
stall  output  1  hold IF/ID/EX
wb_valid  output  1  one-cycle result-valid pulse
wb_rd  output  5  result destination
wb_data  output  XLEN  result
busy  output  1  state != IDLE
err_timeout  output  1  sticky MU-hang flag

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. All flops clear on rst_n=0.
- Reset values: state=IDLE, all outputs 0, counter 0. Reset in any state aborts silently; no wb_valid and no mul_abort is generated.
- accept = issue_valid & is_mul & ~flush. It is sampled in IDLE and DONE.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - On accept: latch mul_op/mul_a/mul_b/wb_rd, then go to START.
  - Otherwise remain in IDLE. Non-mul instructions are ignored.
- START:
  - mul_start=1 for exactly this cycle; counter cleared to 0; next state WAIT.
  - flush: go to IDLE and pulse mul_abort next cycle. mul_start is still asserted this cycle because it is a registered decode of state.
- WAIT:
  - mul_done=1: capture mul_result into wb_data, go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and mul_done=0: set err_timeout (sticky until reset), pulse mul_abort, go to IDLE, no writeback.
  - flush (takes priority over mul_done and timeout): pulse mul_abort, go to IDLE, no writeback.
- DONE:
  - wb_valid=1 for one cycle unless flush=1 in this cycle, which suppresses wb_valid.
  - Back-to-back: accept in DONE latches the new operands and goes to START. wb_rd/wb_data still show the completing result during this cycle.
  - No accept: go to IDLE.
- stall = (state==IDLE & accept) | state==START | state==WAIT. It is combinational, so the stall is seen in the issue cycle. stall=0 in DONE.
- Latency: issue at cycle N gives mul_start at N+1. If mul_done arrives at N+1+k (k>=1), wb_valid is at N+2+k. Minimum issue-to-wb is 3 cycles.
- Ignored inputs:
  - mul_done in IDLE, START or DONE (late or stale done after abort).
  - mulctl_in and operands outside accept cycles.
- mul_start, mul_abort and wb_valid are never asserted together.

Test Plan:
1. Reset, then issue mul with rs1=7, rs2=6, rd=5, mulctl=00; MU raises done 4 cycles after start with result 42. Required: mul_start at cycle 1; stall during cycles 0–5; wb_valid=1 with wb_rd=5 and wb_data=42 at cycle 6; then IDLE.
2. Back-to-back: a second mul (rs1=3, rs2=3, rd=9) is issued in the DONE cycle of scenario 1. Required: the first wb_valid (rd=5, data=42) is unaffected; mul_start fires the next cycle; the second result (data=9, rd=9) is written back.
3. flush in WAIT at cycle 3. Required: mul_abort pulse; IDLE next cycle; no wb_valid even when mul_done arrives at cycle 5; stall drops once in IDLE.
4. TIMEOUT=8 and mul_done held 0. Required: err_timeout=1 and mul_abort after 8 WAIT cycles; return to IDLE; err_timeout stays 1 until rst_n=0.
5. Assert rst_n=0 mid-WAIT. Required: all outputs are 0 immediately, asynchronously; no wb_valid after release.
6. Non-mul R-type (issue_valid=1, is_mul=0) and an issue with flush=1 in the same cycle. Required: stall=0, no mul_start, state stays IDLE.

Source files
------------

// File: rtl/mu_sequencer.sv
// Sequencer for the multi-cycle multiply unit in EX. It latches the operands, starts the MU
// and stalls the pipeline until the MU finishes. It then issues a one-cycle writeback pulse.
module mu_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            is_mul,
  input  logic [1:0]      mulctl_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  input  logic            mul_done,
  input  logic [XLEN-1:0] mul_result,
  output logic            mul_start,
  output logic            mul_abort,
  output logic [1:0]      mul_op,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            err_timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             load;
  logic             capture;
  logic             abort_nxt;
  logic             err_set;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;

  assign accept      = issue_valid & is_mul & ~flush;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    abort_nxt = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (flush) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Flush beats a same-cycle done or timeout: the instruction is dead either way.
        if (flush) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (mul_done) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset as well, so every output reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start   <= 1'b0;
      mul_abort   <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      mul_op      <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      mul_start <= (state_nxt == START);
      mul_abort <= abort_nxt;
      if (err_set) err_timeout <= 1'b1;
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      if (load) begin
        mul_op <= mulctl_in;
        mul_a  <= rs1_data;
        mul_b  <= rs2_data;
        wb_rd  <= rd_in;
      end
      if (capture) wb_data <= mul_result;
    end
  end

  // Stall is combinational so the issuing instruction is held in the same cycle.
  assign stall    = ((state == IDLE) & accept) | (state == START) | (state == WAIT);
  assign wb_valid = (state == DONE) & ~flush;
  assign busy     = (state != IDLE);

endmodule
